// File: rtl/pop_arbiter.sv
// pop_arbiter
//   Round-robin arbiter that lets four requesters share a single FIFO read
//   port. One pop is outstanding at a time: a winner is chosen in IDLE, a
//   one-cycle pop strobe is issued in ISSUE, and WAIT holds the grant until
//   the FIFO returns data or a timeout expires.
//
// Parameters
//   DATA_WIDTH  FIFO data word width in bits
//   TIMEOUT     maximum WAIT cycles allowed for the FIFO to answer (1..255)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   req[3:0]    level-sensitive pop requests, bit i = requester i
//   emptyIn     shared FIFO empty flag
//   dataIn      shared FIFO read data
//   popValidIn  qualifies dataIn (only honoured in WAIT)
//   popOut      registered one-cycle pop strobe to the FIFO
//   gnt[3:0]    registered one-hot grant, held from ISSUE through WAIT
//   dataOut     last delivered word, held until the next delivery
//   dataValid   one-cycle one-hot delivery strobe to the granted requester
//   busy        high whenever the arbiter is not idle
//   errOut      one-cycle pulse when WAIT times out
module pop_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic                  emptyIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  popValidIn,
  output logic                  popOut,
  output logic [3:0]            gnt,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [3:0]            dataValid,
  output logic                  busy,
  output logic                  errOut
);

  // Encoding 2'b11 is unused; the default branch returns it to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state_r;
  state_t                state_nx_s;
  logic [3:0]            gnt_r;
  logic [3:0]            gnt_nx_s;
  logic [1:0]            last_r;
  logic [1:0]            last_nx_s;
  logic [7:0]            cnt_r;
  logic [7:0]            cnt_nx_s;
  logic                  pop_r;
  logic                  pop_nx_s;
  logic [DATA_WIDTH-1:0] dout_r;
  logic [DATA_WIDTH-1:0] dout_nx_s;
  logic [3:0]            dv_r;
  logic [3:0]            dv_nx_s;
  logic                  busy_r;
  logic                  busy_nx_s;
  logic                  err_r;
  logic                  err_nx_s;

  logic [1:0]            cand_s;
  logic [1:0]            win_idx_s;
  logic                  win_found_s;
  logic [3:0]            win_onehot_s;
  logic [1:0]            gnt_idx_s;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    cand_s      = last_r;
    win_idx_s   = last_r;
    win_found_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand_s = last_r + 2'(k);
      if (!win_found_s && req[cand_s]) begin
        win_idx_s   = cand_s;
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_onehot_s = 4'b0001 << win_idx_s;
  end

  // Index of the currently granted requester, used to update last_r.
  always_comb begin
    case (gnt_r)
      4'b0001: gnt_idx_s = 2'd0;
      4'b0010: gnt_idx_s = 2'd1;
      4'b0100: gnt_idx_s = 2'd2;
      4'b1000: gnt_idx_s = 2'd3;
      default: gnt_idx_s = 2'd0;
    endcase
  end

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_nx_s = state_r;
    gnt_nx_s   = gnt_r;
    last_nx_s  = last_r;
    cnt_nx_s   = cnt_r;
    pop_nx_s   = 1'b0;
    dout_nx_s  = dout_r;
    dv_nx_s    = 4'b0000;
    err_nx_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((req != 4'b0000) && !emptyIn) begin
          gnt_nx_s   = win_onehot_s;
          pop_nx_s   = 1'b1;
          state_nx_s = ST_ISSUE;
        end else begin
          gnt_nx_s   = 4'b0000;
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The pop is already committed; nothing here can cancel it.
        cnt_nx_s   = 8'd0;
        state_nx_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (popValidIn) begin
          dout_nx_s  = dataIn;
          dv_nx_s    = gnt_r;
          last_nx_s  = gnt_idx_s;
          gnt_nx_s   = 4'b0000;
          cnt_nx_s   = 8'd0;
          state_nx_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          // Timed out: the slot still counts as served for fairness.
          err_nx_s   = 1'b1;
          last_nx_s  = gnt_idx_s;
          gnt_nx_s   = 4'b0000;
          cnt_nx_s   = 8'd0;
          state_nx_s = ST_IDLE;
        end else begin
          cnt_nx_s = cnt_r + 8'd1;
        end
      end
      default: begin
        gnt_nx_s   = 4'b0000;
        cnt_nx_s   = 8'd0;
        state_nx_s = ST_IDLE;
      end
    endcase
    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      gnt_r   <= 4'b0000;
      last_r  <= 2'd3;
      cnt_r   <= 8'd0;
      pop_r   <= 1'b0;
      dout_r  <= {DATA_WIDTH{1'b0}};
      dv_r    <= 4'b0000;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      gnt_r   <= gnt_nx_s;
      last_r  <= last_nx_s;
      cnt_r   <= cnt_nx_s;
      pop_r   <= pop_nx_s;
      dout_r  <= dout_nx_s;
      dv_r    <= dv_nx_s;
      busy_r  <= busy_nx_s;
      err_r   <= err_nx_s;
    end
  end

  assign popOut    = pop_r;
  assign gnt       = gnt_r;
  assign dataOut   = dout_r;
  assign dataValid = dv_r;
  assign busy      = busy_r;
  assign errOut    = err_r;

endmodule

// File: tb/tb_pop_arbiter.sv
// tb_pop_arbiter
//   Self-checking bench for pop_arbiter. A transaction-level reference model
//   predicts every output after each rising edge; directed scenarios cover
//   the called-out cases and a randomized phase follows.
module tb_pop_arbiter;

  localparam int DW = 8;
  localparam int TO = 4;

  logic          clk;
  logic          reset;
  logic [3:0]    req;
  logic          emptyIn;
  logic [DW-1:0] dataIn;
  logic          popValidIn;
  logic          popOut;
  logic [3:0]    gnt;
  logic [DW-1:0] dataOut;
  logic [3:0]    dataValid;
  logic          busy;
  logic          errOut;

  pop_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .emptyIn(emptyIn), .dataIn(dataIn),
    .popValidIn(popValidIn), .popOut(popOut), .gnt(gnt), .dataOut(dataOut),
    .dataValid(dataValid), .busy(busy), .errOut(errOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit            m_active;
  int            m_age;
  int            m_win;
  int            m_last;
  logic [3:0]    e_gnt;
  logic          e_pop;
  logic [3:0]    e_dv;
  logic          e_err;
  logic [DW-1:0] e_dout;
  logic          e_busy;

  bit fifo_auto;
  bit prev_pop;
  int cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_age    = 0;
    m_win    = 0;
    m_last   = 3;
    e_gnt    = 4'b0000;
    e_pop    = 1'b0;
    e_dv     = 4'b0000;
    e_err    = 1'b0;
    e_dout   = '0;
    e_busy   = 1'b0;
  endtask

  // One rising edge of the block as seen from the requesters' side.
  task automatic model_step();
    bit found;
    int idx;
    e_dv  = 4'b0000;
    e_err = 1'b0;
    e_pop = 1'b0;
    if (!m_active) begin
      e_gnt = 4'b0000;
      if (req != 4'b0000 && !emptyIn) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (!found && req[idx]) begin
            m_win = idx;
            found = 1'b1;
          end
        end
        m_active = 1'b1;
        m_age    = 1;
        e_gnt    = 4'(1 << m_win);
        e_pop    = 1'b1;
      end
    end else if (m_age == 1) begin
      m_age = 2;                          // pop issued, now waiting
    end else if (popValidIn) begin
      e_dout   = dataIn;
      e_dv     = e_gnt;
      m_last   = m_win;
      m_active = 1'b0;
      e_gnt    = 4'b0000;
    end else if (m_age - 2 == TO - 1) begin
      e_err    = 1'b1;
      m_last   = m_win;
      m_active = 1'b0;
      e_gnt    = 4'b0000;
    end else begin
      m_age++;
    end
    e_busy = m_active;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_pop"},  popOut,    e_pop);
    check_eq({tag, "_gnt"},  gnt,       e_gnt);
    check_eq({tag, "_dout"}, dataOut,   e_dout);
    check_eq({tag, "_dv"},   dataValid, e_dv);
    check_eq({tag, "_busy"}, busy,      e_busy);
    check_eq({tag, "_err"},  errOut,    e_err);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pop"},  popOut,    32'd0);
    check_eq({tag, "_gnt"},  gnt,       32'd0);
    check_eq({tag, "_dout"}, dataOut,   32'd0);
    check_eq({tag, "_dv"},   dataValid, 32'd0);
    check_eq({tag, "_busy"}, busy,      32'd0);
    check_eq({tag, "_err"},  errOut,    32'd0);
  endtask

  // Apply one clock: predict, advance, compare, then drive the FIFO side.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs(tag);
    if (fifo_auto) begin
      popValidIn = prev_pop;
    end
    prev_pop = e_pop;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    popValidIn = 1'b0;
    prev_pop   = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    reset = 1'b1;
  endtask

  task automatic drain();
    req       = 4'b0000;
    fifo_auto = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy) tick("drain");
    end
    check_eq("drain_idle", busy, 32'd0);
  endtask

  logic [3:0]    exp_order [5];
  logic [3:0]    got_gnt   [$];
  int            got_cyc   [$];
  logic [DW-1:0] d_saved;
  int            n_wait;
  bit            seen;
  logic [3:0]    dv_seen;

  initial begin
    reset      = 1'b0;
    req        = 4'b0000;
    emptyIn    = 1'b1;
    dataIn     = '0;
    popValidIn = 1'b0;
    fifo_auto  = 1'b0;
    prev_pop   = 1'b0;
    cyc        = 0;
    model_reset();
    do_reset();

    // single request, FIFO answers one cycle after the pop
    req = 4'b0001; emptyIn = 1'b0; dataIn = 8'hA5; fifo_auto = 1'b1;
    tick("s1");
    req = 4'b0000;
    tick("s1");
    tick("s1");
    check_eq("s1_dv", dataValid, 32'h1);
    check_eq("s1_data", dataOut, 32'hA5);
    tick("s1");
    check_eq("s1_busy", busy, 32'd0);

    // all requesting: fairness and 3-cycle pop spacing
    do_reset();
    req = 4'b1111; emptyIn = 1'b0; fifo_auto = 1'b1;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int i = 0; i < 13; i++) begin
      dataIn = 8'(i * 7 + 3);
      tick("s2");
      if (popOut) begin
        got_gnt.push_back(gnt);
        got_cyc.push_back(cyc);
      end
    end
    check_eq("s2_npops", got_gnt.size(), 32'd5);
    for (int i = 0; i < 5 && i < got_gnt.size(); i++) begin
      check_eq("s2_order", got_gnt[i], exp_order[i]);
      if (i > 0) check_eq("s2_gap", got_cyc[i] - got_cyc[i-1], 32'd3);
    end
    drain();

    // held off by an empty FIFO
    req = 4'b0100; emptyIn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("s3");
      check_eq("s3_no_pop", popOut, 32'd0);
    end
    emptyIn = 1'b0;
    tick("s3");
    check_eq("s3_gnt", gnt, 32'h4);
    drain();

    // FIFO never answers: timeout
    fifo_auto = 1'b0; popValidIn = 1'b0; req = 4'b0011; emptyIn = 1'b0;
    d_saved = dataOut;
    tick("s4");
    check_eq("s4_gnt0", gnt, 32'h1);
    n_wait = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        tick("s4");
        n_wait++;
        if (errOut) seen = 1'b1;
      end
    end
    check_eq("s4_err_seen", seen, 32'd1);
    check_eq("s4_err_lat", n_wait, 32'd5);
    check_eq("s4_dout_kept", dataOut, d_saved);
    tick("s4");
    check_eq("s4_next_gnt", gnt, 32'h2);
    drain();

    // reset during WAIT abandons the transaction
    do_reset();
    fifo_auto = 1'b0; popValidIn = 1'b0; req = 4'b1000; emptyIn = 1'b0;
    tick("s5");
    tick("s5");
    check_eq("s5_in_wait", busy, 32'd1);
    reset = 1'b0;
    popValidIn = 1'b1;
    model_reset();
    #1;
    check_all_zero("s5_rst");
    @(posedge clk);
    #1;
    check_all_zero("s5_rst_edge");
    reset = 1'b1; req = 4'b1111; popValidIn = 1'b0; prev_pop = 1'b0; fifo_auto = 1'b1;
    tick("s5");
    check_eq("s5_first_gnt", gnt, 32'h1);
    drain();

    // granted requester drops its request during ISSUE
    req = 4'b0010; emptyIn = 1'b0; fifo_auto = 1'b1; dataIn = 8'h3C;
    tick("s6");
    req = 4'b0000;
    dv_seen = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick("s6");
      if (dataValid != 4'b0000) dv_seen = dataValid;
    end
    check_eq("s6_dv", dv_seen, 32'h2);

    // randomized traffic, FIFO alternately well-behaved and erratic
    for (int blk = 0; blk < 8; blk++) begin
      fifo_auto = blk[0];
      for (int i = 0; i < 50; i++) begin
        req     = 4'($urandom_range(0, 15));
        emptyIn = ($urandom_range(0, 3) == 0);
        dataIn  = 8'($urandom);
        if (!fifo_auto) popValidIn = ($urandom_range(0, 2) == 0);
        tick("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
